// File: rtl/rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_pkg
// Shared definitions for the round-robin arbiter:
//   - arb_state_t : controller state encoding (IDLE = no owner, GRANT = owner)
//   - DEFAULT_N, DEFAULT_MAX_HOLD : default parameter values for rr_arbiter
// -----------------------------------------------------------------------------
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_MAX_HOLD = 8;

endpackage : rr_arbiter_pkg

// File: rtl/rr_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection.
// Ports:
//   req    [N-1:0] in  : request vector
//   ptr    [N-1:0] in  : one-hot priority pointer (search starts here)
//   winner [N-1:0] out : one-hot winner, all-zero when no request is set
//   found          out : 1 when any request is set
// The search runs circularly upward from the pointer bit, wrapping N-1 -> 0.
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] winner,
    output logic         found
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] upper_mask;
    logic [N-1:0] upper_req;

    // Bits at or above the pointer position. With a one-hot pointer,
    // ptr - 1 sets every bit strictly below it.
    assign upper_mask = ~(ptr - ONE);
    assign upper_req  = req & upper_mask;

    // Lowest set bit of the upper half wins; otherwise wrap and take the
    // lowest set bit of the whole request vector.
    always_comb begin
        winner = '0;
        if (|upper_req) begin
            winner = upper_req & (~upper_req + ONE);
        end else begin
            winner = req & (~req + ONE);
        end
    end

    assign found = |req;

endmodule : rr_pick

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with registered one-hot grant and optional grant timeout.
// Parameters:
//   N        : number of requesters (>= 2)
//   MAX_HOLD : grant-timeout limit in cycles (>= 2), used only with timeout on
// Ports:
//   clk       in           : clock, all state updates on the rising edge
//   reset     in           : synchronous active-high reset
//   en        in           : arbitration enable (blocks new grants only)
//   req       in  [N-1:0]  : request vector
//   gnt       out [N-1:0]  : registered one-hot grant or all-zero
//   gnt_valid out          : registered OR of gnt
//   gnt_idx   out [W-1:0]  : registered binary owner index, 0 when idle
// Configuration macro:
//   RR_ARBITER_TIMEOUT_EN : when defined, an owner that has held the grant
//   for MAX_HOLD cycles is revoked if another enabled requester is waiting.
// -----------------------------------------------------------------------------
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    localparam int W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    if (N < 2 || MAX_HOLD < 2) begin : g_bad_param
        $error("rr_arbiter: N and MAX_HOLD must both be >= 2");
    end

    localparam logic [N-1:0] PTR_INIT = {{(N-1){1'b0}}, 1'b1};

    arb_state_t   state_reg, state_next;
    logic [N-1:0] ptr_reg, ptr_next;
    logic [N-1:0] gnt_reg, gnt_next;
    logic         gnt_valid_reg;
    logic [W-1:0] gnt_idx_reg, gnt_idx_next;

    logic [N-1:0] ptr_rot;
    logic [N-1:0] pick_ptr;
    logic [N-1:0] winner;
    logic         found;
    logic         owner_req;
    logic         others_req;
    logic         timeout;
    logic         new_grant;

    // Pointer position just past the current owner.
    assign ptr_rot    = {gnt_reg[N-2:0], gnt_reg[N-1]};
    assign owner_req  = |(req & gnt_reg);
    assign others_req = |(req & ~gnt_reg);

    // In GRANT the only decision ever taken uses the rotated pointer
    // (release or timeout), so the single picker is fed that directly.
    assign pick_ptr = (state_reg == GRANT) ? ptr_rot : ptr_reg;

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner),
        .found  (found)
    );

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_reg, hold_next;

    assign timeout = (state_reg == GRANT) && (hold_reg == HOLD_LAST) && en && others_req;

    // Clears on every new grant, counts each held GRANT cycle and
    // saturates so a lone requester keeps its grant indefinitely.
    always_comb begin
        hold_next = hold_reg;
        if (new_grant) begin
            hold_next = '0;
        end else if (state_reg == GRANT && hold_reg != HOLD_LAST) begin
            hold_next = hold_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg <= '0;
        end else begin
            hold_reg <= hold_next;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        new_grant  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en && found) begin
                    gnt_next   = winner;
                    state_next = GRANT;
                    new_grant  = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req || timeout) begin
                    ptr_next = ptr_rot;
                    if (en && found) begin
                        gnt_next  = winner;
                        new_grant = 1'b1;
                    end else begin
                        gnt_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                gnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // One-hot to binary for the registered index.
    always_comb begin
        gnt_idx_next = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_next[i]) begin
                gnt_idx_next = gnt_idx_next | W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= PTR_INIT;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            gnt_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= |gnt_next;
            gnt_idx_reg   <= gnt_idx_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_valid = gnt_valid_reg;
    assign gnt_idx   = gnt_idx_reg;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
// Self-checking bench for rr_arbiter (N=4, MAX_HOLD=4). Directed scenarios
// with literal expected grants, followed by randomized traffic compared each
// cycle against an integer-level round-robin reference model. Honours
// RR_ARBITER_TIMEOUT_EN so the same bench works with the timeout on or off.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
    localparam int W  = 2;

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [W-1:0] gnt_idx;

    always #5 clk = ~clk;

    rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: owner index (-1 = none), pointer index, hold count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int search(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model(input logic [N-1:0] r, input logic e, input logic rs);
        int  w;
        bit  rel;
        bit  to;
        bit  others;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            w = search(r, m_ptr);
            if (e && w >= 0) begin
                m_owner = w;
                m_hold  = 0;
            end
        end else begin
            others = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others = 1'b1;
            rel = !r[m_owner];
            to  = TO_EN && (m_hold == MH - 1) && e && others;
            if (rel || to) begin
                m_ptr   = (m_owner + 1) % N;
                w       = e ? search(r, m_ptr) : -1;
                m_owner = w;
                m_hold  = 0;
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, and check all outputs against the model.
    task automatic step(input logic [N-1:0] r, input logic e, input logic rs,
                        output logic [N-1:0] g);
        logic [N-1:0] exp_gnt;
        req   = r;
        en    = e;
        reset = rs;
        model(r, e, rs);
        @(posedge clk);
        #1;
        exp_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        $display("t=%0t rst=%b en=%b req=%b gnt=%b valid=%b idx=%0d", $time, rs, e, r, gnt, gnt_valid, gnt_idx);
        check("gnt_model", gnt, exp_gnt);
        check("valid_model", gnt_valid, (m_owner >= 0));
        check("idx_model", gnt_idx, (m_owner >= 0) ? m_owner : 0);
        g = gnt;
    endtask

    task automatic step_exp(input logic [N-1:0] r, input logic e, input logic rs,
                            input logic [N-1:0] exp_g, input string tag);
        logic [N-1:0] g;
        step(r, e, rs, g);
        check(tag, g, exp_g);
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] cur;
        logic [N-1:0] r;
        logic         e;
        logic         rs;

        req   = '0;
        en    = 1'b0;
        reset = 1'b1;

        // Reset held two cycles with full requests: no grant.
        step_exp(4'b1111, 1'b1, 1'b1, 4'b0000, "reset_hold0");
        step_exp(4'b1111, 1'b1, 1'b1, 4'b0000, "reset_hold1");
        step_exp(4'b1111, 1'b1, 1'b0, 4'b0001, "first_grant");
        check("first_idx", gnt_idx, 0);

        // Rotation with no idle cycles: each owner holds, then drops.
        cur = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step_exp(4'b1111, 1'b1, 1'b0, cur, "rot_hold");
            step_exp(4'b1111 & ~cur, 1'b1, 1'b0, {cur[N-2:0], cur[N-1]}, "rot_next");
            cur = {cur[N-2:0], cur[N-1]};
        end

        // Enable gating and grant continuation with en=0.
        step_exp(4'b0000, 1'b1, 1'b1, 4'b0000, "en_reset");
        for (int k = 0; k < 5; k++) step_exp(4'b0110, 1'b0, 1'b0, 4'b0000, "en_off_idle");
        step_exp(4'b0110, 1'b1, 1'b0, 4'b0010, "en_on_grant");
        step_exp(4'b0110, 1'b0, 1'b0, 4'b0010, "en_off_hold");
        step_exp(4'b0100, 1'b0, 1'b0, 4'b0000, "en_off_release");

        // Wrap-around: pointer moved to bit 2, then req=0011 picks bit 0.
        step_exp(4'b0000, 1'b1, 1'b1, 4'b0000, "wrap_reset");
        step_exp(4'b0010, 1'b1, 1'b0, 4'b0010, "wrap_g1");
        step_exp(4'b0000, 1'b1, 1'b0, 4'b0000, "wrap_rel");
        step_exp(4'b0011, 1'b1, 1'b0, 4'b0001, "wrap_pick");

        // Reset mid-grant clears the pointer as well as the grant.
        step_exp(4'b1000, 1'b1, 1'b1, 4'b0000, "mid_reset0");
        step_exp(4'b1000, 1'b1, 1'b0, 4'b1000, "mid_g3");
        step_exp(4'b1000, 1'b1, 1'b1, 4'b0000, "mid_reset");
        step_exp(4'b1001, 1'b1, 1'b0, 4'b0001, "after_reset");

        // Timeout behaviour with two steady requesters.
        step_exp(4'b0000, 1'b1, 1'b1, 4'b0000, "to_reset");
        for (int t = 0; t < 12; t++) begin
            if (TO_EN) cur = (((t / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
            else       cur = 4'b0001;
            step_exp(4'b0011, 1'b1, 1'b0, cur, "timeout_pair");
        end
        // Lone requester keeps its grant regardless of timeout.
        step_exp(4'b0000, 1'b1, 1'b1, 4'b0000, "lone_reset");
        for (int t = 0; t < 10; t++) step_exp(4'b0001, 1'b1, 1'b0, 4'b0001, "lone_hold");

        // Randomized traffic checked against the model.
        r = $urandom_range(0, 15);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) r = $urandom_range(0, 15);
            else if (m_owner >= 0 && $urandom_range(0, 7) == 0) r[m_owner] = 1'b0;
            e  = ($urandom_range(0, 4) != 0);
            rs = ($urandom_range(0, 59) == 0);
            step(r, e, rs, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arbiter

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; the design SHALL support N >= 2.
REQ-002 Parameter MAX_HOLD, default 8: grant-timeout limit in cycles; it SHALL be >= 2.
REQ-003 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 en  input  1: arbitration enable.
REQ-006 req  input  N: request vector, bit i for requester i.
REQ-007 gnt  output  N: registered one-hot grant, or all-zero.
REQ-008 gnt_valid  output  1: registered; equals OR of gnt.
REQ-009 gnt_idx  output  $clog2(N): registered binary index of the owner; 0 when gnt_valid=0.

Function
REQ-010 The block SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-011 The priority pointer SHALL be an N-bit one-hot ring register; it resets to bit 0 set and moves only on grant release or timeout.
REQ-012 Pick rule: the winner SHALL be the first set req bit searching circularly from the pointer position upward, wrapping N-1 to 0.
REQ-013 IDLE, en=1, req!=0 at an edge: gnt SHALL show the winner after that edge (1-cycle latency), and the state SHALL go to GRANT.
REQ-014 IDLE, en=0 or req=0: the block SHALL stay in IDLE with gnt=0.
REQ-015 GRANT, req[owner]=1: gnt SHALL hold unchanged, subject to REQ-021.
REQ-016 GRANT, req[owner]=0 at an edge: on that edge the pointer SHALL rotate to owner+1 (mod N).
REQ-017 Under REQ-016 with en=1, the new winner SHALL be picked from req on the same edge using the rotated pointer; back-to-back grants SHALL have no idle cycle.
REQ-018 Under REQ-016, if no other req bit is set or en=0, the state SHALL go to IDLE and gnt SHALL be 0.
REQ-019 en=0 SHALL block only new grants; a current grant SHALL continue until it is released.
REQ-020 At most one gnt bit SHALL ever be set; a grant SHALL never go to a requester whose req bit was 0 at the deciding edge.

Reset
REQ-021 reset=1 at an edge SHALL force: gnt=0, gnt_valid=0, gnt_idx=0, pointer=bit 0, hold counter=0, state IDLE. This applies mid-grant, with no grant carried across reset.
REQ-022 While reset=1, req and en SHALL be ignored.

Configuration
REQ-023 Macro RR_ARBITER_TIMEOUT_EN SHALL compile the timeout logic in or out.
REQ-024 Macro defined: a hold counter SHALL clear on each new grant and increment each GRANT cycle. When it reaches MAX_HOLD-1 and any other req bit is set with en=1, the next edge SHALL revoke the owner, rotate the pointer per REQ-016 and grant the next winner. If no other requester is set, the counter SHALL saturate and the grant SHALL hold.
REQ-025 Macro undefined: the counter SHALL be absent and grants SHALL end only on request drop or reset.

Structure
REQ-026 State encodings (IDLE, GRANT) and the default N/MAX_HOLD SHALL live in the shared defs.v include.
REQ-027 A combinational sub-module rr_pick SHALL take req and the one-hot pointer and return the one-hot winner plus a found flag. It is instantiated once.
REQ-028 The top level SHALL hold the state, pointer, counter and output registers.

Verification (N=4, MAX_HOLD=4)
REQ-029 reset=1 for 2 cycles with req=1111, en=1 -> gnt=0000 throughout; first edge after reset deasserts -> gnt=0001, gnt_idx=0.
REQ-030 req=1111, each owner drops its req 2 cycles after grant and re-raises it the cycle after -> gnt sequence 0001,0010,0100,1000,0001 with no idle cycles.
REQ-031 en=0, req=0110 for 5 cycles -> gnt=0000; en=1 -> gnt=0010 one edge later; en=0 mid-grant -> grant held until req[1] drops, then gnt=0000.
REQ-032 RR_ARBITER_TIMEOUT_EN defined, req=0011 held -> gnt 0001 for 4 cycles, 0010 for 4 cycles, then 0001. Same with req=0001 alone -> 0001 held indefinitely. Macro undefined, req=0011 -> 0001 indefinitely.
REQ-033 Pointer at bit 2, req=0011 -> gnt=0001 (wrap-around). reset=1 while gnt=1000 -> next edge gnt=0000; the next grant for req=1001 SHALL be 0001.
